// File: rtl/cam_search_engine.sv
// cam_search_engine: valid-tagged CAM with binary-addressed writes/invalidates,
// a valid/ready search port, a pipelined compare/priority-encode path and a
// multi-cycle flush state machine that clears every valid bit.
module cam_search_engine #(
  parameter int CAM_WIDTH  = 8,
  parameter int CAM_DEPTH  = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [CAM_WIDTH-1:0]  wr_data,
  input  logic                  wr_set,
  input  logic                  flush_req,
  output logic                  busy,
  input  logic                  srch_valid,
  output logic                  srch_ready,
  input  logic [CAM_WIDTH-1:0]  srch_key,
  input  logic [CAM_WIDTH-1:0]  srch_mask,
  output logic                  res_valid,
  output logic                  res_hit,
  output logic                  res_multi,
  output logic [ADDR_WIDTH-1:0] res_addr,
  output logic [CAM_DEPTH-1:0]  res_vec
);

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] flush_cnt;
  logic [CAM_WIDTH-1:0]  entry [CAM_DEPTH];
  logic [CAM_DEPTH-1:0]  valid;

  logic                  accept;
  logic                  flush_go;
  logic                  wr_go;
  logic                  flush_last;
  logic [CAM_DEPTH-1:0]  match_vec;

  // match-capture stage (loaded on the accept edge)
  logic                  s1_valid;
  logic [CAM_DEPTH-1:0]  s1_vec;
  // encoded stage
  logic                  s2_valid;
  logic                  s2_hit;
  logic                  s2_multi;
  logic [ADDR_WIDTH-1:0] s2_addr;
  logic [CAM_DEPTH-1:0]  s2_vec;

  logic                  enc_hit;
  logic                  enc_multi;
  logic [ADDR_WIDTH-1:0] enc_addr;
  logic                  enc_found;

  // Control strobes derived from the current state and request inputs.
  always_comb begin
    accept     = srch_valid && (state == IDLE);
    flush_go   = flush_req && (state == IDLE);
    wr_go      = wr_en && (state == IDLE) && !flush_req;
    flush_last = (flush_cnt == ADDR_WIDTH'(CAM_DEPTH - 1));
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state logic; flush requests during FLUSH are ignored.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (flush_req) state_nxt = FLUSH;
      FLUSH:   if (flush_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs, decoded from state only.
  always_comb begin
    busy       = (state == FLUSH);
    srch_ready = (state == IDLE);
  end

  // Flush index counter: restarts on flush entry, advances every FLUSH cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flush_cnt <= '0;
    end else if (flush_go) begin
      flush_cnt <= '0;
    end else if (state == FLUSH) begin
      flush_cnt <= flush_cnt + 1'b1;
    end
  end

  // Entry storage and valid bits: writes/invalidates in IDLE, one clear per FLUSH cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= '0;
      for (int unsigned i = 0; i < CAM_DEPTH; i++) begin
        entry[i] <= '0;
      end
    end else if (state == FLUSH) begin
      valid[flush_cnt] <= 1'b0;
    end else if (wr_go) begin
      if (wr_set) begin
        entry[wr_addr] <= wr_data;
        valid[wr_addr] <= 1'b1;
      end else begin
        valid[wr_addr] <= 1'b0;
      end
    end
  end

  // Masked compare of the live key against every valid entry.
  always_comb begin
    match_vec = '0;
    for (int unsigned i = 0; i < CAM_DEPTH; i++) begin
      match_vec[i] = valid[i] && (((entry[i] ^ srch_key) & ~srch_mask) == '0);
    end
  end

  // The match vector is captured on the accept edge itself so a write on that
  // edge stays invisible to the search; encode and output registers follow,
  // giving a result in the cycle after the second edge past acceptance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_vec   <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_vec <= match_vec;
      end
    end
  end

  // Priority encoder: lowest set index wins; multi when two or more bits set.
  always_comb begin
    enc_addr  = '0;
    enc_found = 1'b0;
    for (int unsigned i = 0; i < CAM_DEPTH; i++) begin
      if (s1_vec[i] && !enc_found) begin
        enc_addr  = ADDR_WIDTH'(i);
        enc_found = 1'b1;
      end
    end
    enc_hit   = |s1_vec;
    enc_multi = |(s1_vec & (s1_vec - CAM_DEPTH'(1)));
  end

  // Encoded-result stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_hit   <= 1'b0;
      s2_multi <= 1'b0;
      s2_addr  <= '0;
      s2_vec   <= '0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_hit   <= enc_hit;
        s2_multi <= enc_multi;
        s2_addr  <= enc_addr;
        s2_vec   <= s1_vec;
      end
    end
  end

  // Result outputs: strobe for one cycle, fields hold between results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid <= 1'b0;
      res_hit   <= 1'b0;
      res_multi <= 1'b0;
      res_addr  <= '0;
      res_vec   <= '0;
    end else begin
      res_valid <= s2_valid;
      if (s2_valid) begin
        res_hit   <= s2_hit;
        res_multi <= s2_multi;
        res_addr  <= s2_addr;
        res_vec   <= s2_vec;
      end
    end
  end

endmodule

// File: tb/tb_cam_search_engine.sv
// Self-checking bench for cam_search_engine: directed test-plan scenarios
// followed by randomized traffic, all checked against a behavioural model.
module tb_cam_search_engine;

  localparam int W = 8;
  localparam int D = 8;
  localparam int A = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic         wr_en;
  logic [A-1:0] wr_addr;
  logic [W-1:0] wr_data;
  logic         wr_set;
  logic         flush_req;
  logic         busy;
  logic         srch_valid;
  logic         srch_ready;
  logic [W-1:0] srch_key;
  logic [W-1:0] srch_mask;
  logic         res_valid;
  logic         res_hit;
  logic         res_multi;
  logic [A-1:0] res_addr;
  logic [D-1:0] res_vec;

  cam_search_engine #(.CAM_WIDTH(W), .CAM_DEPTH(D), .ADDR_WIDTH(A)) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_set     (wr_set),
    .flush_req  (flush_req),
    .busy       (busy),
    .srch_valid (srch_valid),
    .srch_ready (srch_ready),
    .srch_key   (srch_key),
    .srch_mask  (srch_mask),
    .res_valid  (res_valid),
    .res_hit    (res_hit),
    .res_multi  (res_multi),
    .res_addr   (res_addr),
    .res_vec    (res_vec)
  );

  always #5 clk = ~clk;

  // behavioural model
  typedef struct {
    int           due;
    logic [D-1:0] vec;
  } exp_t;

  exp_t         q[$];
  logic [W-1:0] m_data [D];
  logic [D-1:0] m_valid;
  int           flush_left;
  int           fidx;
  int           cyc;
  logic [D-1:0] last_vec;
  logic         last_hit;
  logic         last_multi;
  logic [A-1:0] last_addr;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [A-1:0] lowest(input logic [D-1:0] v);
    for (int i = 0; i < D; i++) begin
      if (v[i]) return A'(i);
    end
    return '0;
  endfunction

  task automatic idle_inputs();
    wr_en      = 1'b0;
    wr_addr    = '0;
    wr_data    = '0;
    wr_set     = 1'b0;
    flush_req  = 1'b0;
    srch_valid = 1'b0;
    srch_key   = '0;
    srch_mask  = '0;
  endtask

  // One clock: update the model from the inputs seen at the edge, then check
  // every output at the following falling edge.
  task automatic step();
    logic [D-1:0] v;
    exp_t         e;
    @(posedge clk);
    cyc++;
    if (flush_left == 0) begin
      if (srch_valid) begin
        v = '0;
        for (int i = 0; i < D; i++) begin
          if (m_valid[i] && (((m_data[i] ^ srch_key) & ~srch_mask) == '0)) v[i] = 1'b1;
        end
        q.push_back('{due: cyc + 2, vec: v});
      end
      if (flush_req) begin
        flush_left = D;
        fidx       = 0;
      end else if (wr_en) begin
        if (wr_set) begin
          m_data[wr_addr]  = wr_data;
          m_valid[wr_addr] = 1'b1;
        end else begin
          m_valid[wr_addr] = 1'b0;
        end
      end
    end else begin
      m_valid[fidx] = 1'b0;
      fidx++;
      flush_left--;
    end
    @(negedge clk);
    check("busy", 32'(busy), 32'(flush_left != 0));
    check("srch_ready", 32'(srch_ready), 32'(flush_left == 0));
    if (q.size() > 0 && q[0].due == cyc) begin
      e          = q.pop_front();
      last_vec   = e.vec;
      last_hit   = (e.vec != '0);
      last_multi = ($countones(e.vec) >= 2);
      last_addr  = lowest(e.vec);
      check("res_valid", 32'(res_valid), 32'd1);
    end else begin
      check("res_valid", 32'(res_valid), 32'd0);
    end
    check("res_vec", 32'(res_vec), 32'(last_vec));
    check("res_hit", 32'(res_hit), 32'(last_hit));
    check("res_multi", 32'(res_multi), 32'(last_multi));
    check("res_addr", 32'(res_addr), 32'(last_addr));
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_res_vec", 32'(res_vec), 32'd0);
    check("rst_res_addr", 32'(res_addr), 32'd0);
    check("rst_res_hit", 32'(res_hit), 32'd0);
    q.delete();
    for (int i = 0; i < D; i++) m_data[i] = '0;
    m_valid    = '0;
    flush_left = 0;
    fidx       = 0;
    last_vec   = '0;
    last_hit   = 1'b0;
    last_multi = 1'b0;
    last_addr  = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_srch_ready", 32'(srch_ready), 32'd1);
  endtask

  task automatic wr(input logic [A-1:0] a, input logic [W-1:0] d, input logic s);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    wr_set  = s;
    step();
    wr_en   = 1'b0;
  endtask

  // Single search with explicit expected vector/address, three clocks later.
  task automatic srch_chk(input logic [W-1:0] k, input logic [W-1:0] m,
                          input logic [D-1:0] ev, input logic [A-1:0] ea);
    srch_valid = 1'b1;
    srch_key   = k;
    srch_mask  = m;
    step();
    srch_valid = 1'b0;
    step();
    step();
    check("tp_valid", 32'(res_valid), 32'd1);
    check("tp_vec", 32'(res_vec), 32'(ev));
    check("tp_addr", 32'(res_addr), 32'(ea));
  endtask

  function automatic logic [W-1:0] pick_val();
    case ($urandom_range(0, 5))
      0: return 8'hA5;
      1: return 8'h3C;
      2: return 8'h11;
      3: return 8'hFF;
      4: return 8'h00;
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    int n;
    int guard;
    cyc = 0;
    idle_inputs();
    rst = 1'b1;
    reset_dut();

    // 1: empty table
    srch_chk(8'h00, 8'h00, 8'h00, 3'd0);
    check("t1_hit", 32'(res_hit), 32'd0);
    check("t1_multi", 32'(res_multi), 32'd0);

    // 2: multi-hit
    wr(3'd2, 8'hA5, 1'b1);
    wr(3'd6, 8'hA5, 1'b1);
    wr(3'd5, 8'h3C, 1'b1);
    srch_chk(8'hA5, 8'h00, 8'h44, 3'd2);
    check("t2_hit", 32'(res_hit), 32'd1);
    check("t2_multi", 32'(res_multi), 32'd1);

    // 3: masked search, then invalidate
    srch_chk(8'hA0, 8'h0F, 8'h44, 3'd2);
    wr(3'd2, 8'h00, 1'b0);
    srch_chk(8'hA0, 8'h0F, 8'h40, 3'd6);
    check("t3_multi", 32'(res_multi), 32'd0);

    // 4: back-to-back searches (entry 2 restored first)
    wr(3'd2, 8'hA5, 1'b1);
    srch_valid = 1'b1;
    srch_key = 8'h3C; srch_mask = 8'h00; step();
    srch_key = 8'hA5; srch_mask = 8'h00; step();
    srch_key = 8'hFF; srch_mask = 8'hFF; step();
    srch_valid = 1'b0;
    check("t4_vec0", 32'(res_vec), 32'h20);
    step();
    check("t4_vec1", 32'(res_vec), 32'h44);
    step();
    check("t4_vec2", 32'(res_vec), 32'h64);
    check("t4_valid2", 32'(res_valid), 32'd1);

    // 5: write and search on the same edge
    wr_en = 1'b1; wr_addr = 3'd1; wr_data = 8'h11; wr_set = 1'b1;
    srch_valid = 1'b1; srch_key = 8'h11; srch_mask = 8'h00;
    step();
    wr_en = 1'b0;
    step();
    srch_valid = 1'b0;
    step();
    check("t5_hit_first", 32'(res_hit), 32'd0);
    step();
    check("t5_hit_second", 32'(res_hit), 32'd1);
    check("t5_addr_second", 32'(res_addr), 32'd1);

    // 6: flush length, dropped write, empty table afterwards
    flush_req = 1'b1;
    step();
    flush_req = 1'b0;
    n = 0;
    guard = 0;
    while (busy === 1'b1 && guard < 20) begin
      n++;
      if (n == 3) begin
        wr_en = 1'b1; wr_addr = 3'd3; wr_data = 8'h3C; wr_set = 1'b1;
        flush_req = 1'b1;
      end else begin
        wr_en = 1'b0;
        flush_req = 1'b0;
      end
      step();
      guard++;
    end
    wr_en = 1'b0;
    flush_req = 1'b0;
    check("t6_flush_len", 32'(n), 32'd8);
    srch_chk(8'h00, 8'hFF, 8'h00, 3'd0);

    // 6b: reset in the middle of a flush with a search in flight
    wr(3'd4, 8'h11, 1'b1);
    srch_valid = 1'b1; srch_key = 8'h11; srch_mask = 8'h00;
    flush_req = 1'b1;
    step();
    idle_inputs();
    step();
    reset_dut();
    for (int i = 0; i < 4; i++) step();

    // randomized traffic
    for (int i = 0; i < 500; i++) begin
      idle_inputs();
      srch_valid = ($urandom_range(0, 9) < 6);
      srch_key   = pick_val();
      srch_mask  = ($urandom_range(0, 1) == 0) ? 8'h00 : W'($urandom & $urandom);
      wr_en      = ($urandom_range(0, 9) < 3);
      wr_addr    = A'($urandom);
      wr_data    = pick_val();
      wr_set     = ($urandom_range(0, 3) != 0);
      flush_req  = ($urandom_range(0, 49) == 0);
      step();
    end
    idle_inputs();
    for (int i = 0; i < 4; i++) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cam_search_engine.md
Name: cam_search_engine

Overview:
- Parametrised successor to the flat CAM row array.
- Adds per-entry valid bits, binary-addressed writes and invalidates, and a valid/ready search handshake.
- Search runs through a 2-stage pipeline: compare, then priority encode. Results give hit, multi-hit, lowest matching address and the raw match vector.
- A multi-cycle flush state machine clears all entries. Sits between the lookup controller and the table; both sides are on the same clock.

Parameters:
- CAM_WIDTH, 8, key/entry data width in bits.
- CAM_DEPTH, 8, number of entries; power of two, >= 2.
- ADDR_WIDTH, 3, entry address width; must equal log2(CAM_DEPTH).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- wr_en  in  1  write/invalidate strobe.
- wr_addr  in  ADDR_WIDTH  entry index to write.
- wr_data  in  CAM_WIDTH  data stored on write.
- wr_set  in  1  1 = store wr_data and set valid; 0 = clear valid (data unchanged).
- flush_req  in  1  pulse; starts a flush of all entries.
- busy  out  1  high while flushing.
- srch_valid  in  1  search request valid.
- srch_ready  out  1  engine accepts a search this cycle.
- srch_key  in  CAM_WIDTH  search word.
- srch_mask  in  CAM_WIDTH  per-bit don't-care; 1 = ignore bit.
- res_valid  out  1  result strobe, one cycle per accepted search.
- res_hit  out  1  at least one valid entry matched.
- res_multi  out  1  two or more valid entries matched.
- res_addr  out  ADDR_WIDTH  lowest matching index; 0 when no hit.
- res_vec  out  CAM_DEPTH  match vector; bit i = entry i valid and matched.

Behaviour:
- Reset (async, immediate):
  - All valid bits and entry data go to 0. FSM goes to IDLE; flush counter to 0; pipeline stages are emptied.
  - Outputs: busy=0, srch_ready=1 (once in IDLE), res_valid=0, res_hit=0, res_multi=0, res_addr=0, res_vec=0.
  - Reset mid-search or mid-flush discards all in-flight work; no res_valid is emitted for it.
- Match rule: entry i matches when valid[i]=1 and ((entry[i] XOR srch_key) AND NOT srch_mask) == 0.
  - All-ones mask therefore matches every valid entry.
- Handshake:
  - A search is accepted on a rising edge where srch_valid=1 and srch_ready=1.
  - srch_ready = (state == IDLE). It is combinational from state only, never from srch_valid.
  - Throughput is one search per cycle.
- Latency: search accepted at edge N produces res_valid=1 in the cycle after edge N+2.
  - Stage 1 registers the match vector.
  - Stage 2 registers hit, multi, address and vector.
  - There is no result back-pressure; the consumer must take the result in its res_valid cycle.
  - res_* hold their last value while res_valid=0.
- Write/search ordering: a write on the same edge as search acceptance is not visible to that search (the search sees the pre-write contents). It is visible to a search accepted on the next edge.
- Writes: applied on the edge where wr_en=1 and state==IDLE. They are ignored (dropped) during FLUSH.
- Write vs flush request: wr_en on the same edge as an accepted flush_req is dropped.
- FSM, IDLE:
  - flush_req=1 moves to FLUSH and sets the counter to 0.
  - If srch_valid and flush_req are both high, the search is accepted on that edge and flush starts on the same edge.
- FSM, FLUSH:
  - Each cycle clears valid[counter] and increments the counter.
  - After clearing index CAM_DEPTH-1, returns to IDLE. FLUSH therefore lasts exactly CAM_DEPTH cycles.
  - busy=1 and srch_ready=0 throughout.
  - flush_req during FLUSH is ignored.
- In-flight searches during flush: searches already in stages 1/2 when flush starts complete normally using their captured vector.
- Priority encoder: the lowest set index wins. res_multi is set when popcount(res_vec) >= 2.

Test Plan:
1. Reset then search key 0x00, mask 0x00 -> res_valid two cycles after accept; res_hit=0, res_multi=0, res_addr=0, res_vec=0x00.
2. Write 0xA5 to entries 2 and 6, 0x3C to entry 5; search 0xA5 mask 0x00 -> res_hit=1, res_multi=1, res_addr=2, res_vec=0x44.
3. Search 0xA0 mask 0x0F -> res_vec=0x44, res_addr=2. Then invalidate entry 2 (wr_set=0) and repeat -> res_vec=0x40, res_addr=6, res_multi=0.
4. Back-to-back searches on 3 consecutive cycles (0x3C, 0xA5, 0xFF with mask 0xFF) -> 3 consecutive res_valid cycles; res_vec = 0x20, 0x44, 0x64.
5. Write entry 1=0x11 on the same edge a search for 0x11 is accepted -> res_hit=0; an immediate repeat search -> res_hit=1, res_addr=1.
6. flush_req with CAM_DEPTH=8 -> busy=1 and srch_ready=0 for exactly 8 cycles; a wr_en during flush is dropped; after flush a search with mask 0xFF gives res_vec=0x00. Assert rst mid-flush -> busy=0 immediately, no res_valid emitted.
